a2d_seq: RTL and testbench
==========================

A2D_SEQ -- requirements
Module: a2d_seq

Interface
REQ-001 Parameter DEAD_CYC, default 4: idle clocks between the two SPI transactions of one conversion.
REQ-002 Parameter TMO_CYC, default 2047: clocks to wait for done before abort (used only with A2D_SEQ_TMO_EN).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 nxt  in  1  one-clock request to convert the current round-robin channel.
REQ-006 wrt  out  1  one-clock start pulse to the SPI monarch.
REQ-007 cmd  out  16  SPI command word.
REQ-008 done  in  1  one-clock SPI transaction-complete pulse.
REQ-009 rd_data  in  16  SPI returned word, valid when done=1.
REQ-010 lft_ld, rght_ld, steer_pot, batt  out  12 each  latest converted results.
REQ-011 cnv_cmplt  out  1  one-clock pulse, a result register updated this cycle.
REQ-012 busy  out  1  high from nxt acceptance until return to IDLE.
REQ-013 tmo_err  out  1  sticky abort flag (present only with A2D_SEQ_TMO_EN).

Function
REQ-014 Channel map, fixed: ptr 0=lft_ld/ch0, 1=rght_ld/ch4, 2=steer_pot/ch5, 3=batt/ch6.
REQ-015 cmd = {2'b00, ch[2:0], 11'h000} for both transactions of a conversion; cmd holds stable from wrt until the matching done.
REQ-016 States: IDLE, XFER1, DEAD, XFER2; no other states.
REQ-017 IDLE: nxt=1 -> wrt=1 the next cycle, go XFER1; nxt=0 -> stay.
REQ-018 XFER1: done=1 -> go DEAD; rd_data discarded (ADC is pipelined).
REQ-019 DEAD: count DEAD_CYC clocks, then wrt=1 for one cycle, go XFER2.
REQ-020 XFER2: done=1 -> load rd_data[11:0] into the register selected by ptr on the next edge; cnv_cmplt=1 in that same cycle; ptr = ptr+1 mod 4 (3 wraps to 0); go IDLE.
REQ-021 nxt is ignored outside IDLE and is not queued.
REQ-022 nxt is accepted in the cycle cnv_cmplt=1, since state is already IDLE.
REQ-023 done in IDLE or DEAD is ignored; a stray done has no effect on state or results.
REQ-024 Unselected result registers hold their values.
REQ-025 Latency from nxt to cnv_cmplt = 1 + T1 + DEAD_CYC + 1 + T2 + 1 clocks, where T1 and T2 are the monarch transaction lengths.

Reset
REQ-026 rst=1 at a clock edge forces IDLE, ptr=0, wrt=0, cmd=0, all results 0, cnv_cmplt=0, busy=0, tmo_err=0, dead/timeout counters=0.
REQ-027 Reset mid-conversion abandons it; a later done from that transaction is ignored per REQ-023.

Configuration
REQ-028 Macro A2D_SEQ_TMO_EN defined: a counter runs in XFER1/XFER2 and clears on each wrt; reaching TMO_CYC without done -> tmo_err=1 (sticky until rst), no result update, no cnv_cmplt, ptr advances, go IDLE.
REQ-029 Macro undefined: no tmo_err port, no counter; XFER states wait indefinitely.

Structure
REQ-030 Package a2d_pkg holds the state enum, the 2-bit ptr type, and the ptr-to-channel-code constant table.
REQ-031 One sub-module a2d_seq_tmr: a loadable down-counter shared for the dead-time and timeout functions, with an expire pulse output.
REQ-032 The SPI monarch is external; a2d_seq does not implement SCLK/MOSI.

Verification
REQ-033 Reset, then four nxt pulses with model values lft=12'h350, rght=12'h340, steer=12'h800, batt=12'hC00 -> cmd channels 0,4,5,6 in order; four cnv_cmplt pulses; registers equal the model values.
REQ-034 Fifth nxt -> ptr wraps; cmd channel=0; lft_ld refreshes; the other three registers are unchanged.
REQ-035 nxt pulsed during XFER1 and DEAD -> no extra wrt; exactly one cnv_cmplt per accepted nxt.
REQ-036 rst asserted during DEAD, then a done injected -> all outputs 0, state IDLE, no cnv_cmplt; the next nxt uses channel 0.
REQ-037 Exactly DEAD_CYC=4 idle clocks between the first done and the second wrt; nxt in the cnv_cmplt cycle -> wrt on the next clock.
REQ-038 With A2D_SEQ_TMO_EN, done withheld on ptr=2 -> tmo_err=1 at 2047 clocks after wrt; steer_pot unchanged; the following nxt converts ch6.

Source files
------------

// File: rtl/a2d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a2d_pkg
// Brief    : Shared types and constants for the A2D conversion sequencer:
//            FSM state encoding, round-robin pointer type and the
//            pointer-to-ADC-channel table.
// Revision : 1.0 - initial release
// ============================================================================
package a2d_pkg;

    // Sequencer states; encoding is fixed at 2 bits.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER1 = 2'd1,
        ST_DEAD  = 2'd2,
        ST_XFER2 = 2'd3
    } state_t;

    // Round-robin result pointer (wraps naturally at 4).
    typedef logic [1:0] ptr_t;

    // ADC channel code per pointer slot: [0]=ch0 lft, [1]=ch4 rght,
    // [2]=ch5 steer, [3]=ch6 batt.
    localparam logic [3:0][2:0] c_ch_table = {3'd6, 3'd5, 3'd4, 3'd0};

    // SPI command word for the channel selected by a pointer value.
    function automatic logic [15:0] chan_cmd(input ptr_t p);
        return {2'b00, c_ch_table[p], 11'h000};
    endfunction

endpackage : a2d_pkg
`default_nettype wire

// File: rtl/a2d_seq_tmr.sv
`default_nettype none
// ============================================================================
// Module   : a2d_seq_tmr
// Brief    : Loadable down-counter shared by the sequencer for the dead-time
//            gap and (optionally) the transaction timeout. expire_o is high
//            in the enabled cycle in which the count reads 1, i.e. exactly
//            load_val_i enabled cycles after the load edge.
// Revision : 1.0 - initial release
// ============================================================================
module a2d_seq_tmr #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: a load overrides counting; counting stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == WIDTH'(1));

endmodule : a2d_seq_tmr
`default_nettype wire

// File: rtl/a2d_seq.sv
`default_nettype none
// ============================================================================
// Module   : a2d_seq
// Brief    : Round-robin A2D conversion sequencer. Each accepted nxt issues
//            two SPI transactions on the current channel separated by a dead
//            gap; the second returned word is latched into the selected
//            result register. The SPI monarch itself is external.
// Config   : define A2D_SEQ_TMO_EN to add the transaction timeout and the
//            sticky tmo_err output.
// Revision : 1.0 - initial release
// ============================================================================
module a2d_seq
    import a2d_pkg::*;
#(
    parameter int DEAD_CYC = 4,     // must be >= 1
    parameter int TMO_CYC  = 2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
`ifdef A2D_SEQ_TMO_EN
    output logic        tmo_err,
`endif
    output logic        busy
);

    // Timer is sized for the larger of the two loaded values.
    localparam int c_tmr_max = (DEAD_CYC > TMO_CYC) ? DEAD_CYC : TMO_CYC;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
    localparam logic [c_tmr_w-1:0] c_dead_ld = c_tmr_w'(DEAD_CYC);
`ifdef A2D_SEQ_TMO_EN
    localparam logic [c_tmr_w-1:0] c_tmo_ld  = c_tmr_w'(TMO_CYC);
`endif

    state_t            state_q;
    ptr_t              ptr_q;
    logic              wrt_q;
    logic [15:0]       cmd_q;
    logic [3:0][11:0]  res_q;
    logic              cnv_cmplt_q;
    logic              busy_q;
`ifdef A2D_SEQ_TMO_EN
    logic              tmo_err_q;
`endif

    logic               w_dead_start;
    logic               w_tmr_load;
    logic [c_tmr_w-1:0] w_tmr_val;
    logic               w_tmr_en;
    logic               w_tmr_expire;
    logic               w_unused_rd;

    // The ADC returns 12 significant bits; the upper nibble is don't-care.
    assign w_unused_rd = ^rd_data[15:12];

    assign w_dead_start = (state_q == ST_XFER1) && done;

`ifdef A2D_SEQ_TMO_EN
    // The timeout window restarts on every wrt, so reload on both starts.
    assign w_tmr_load = w_dead_start
                      || ((state_q == ST_IDLE) && nxt)
                      || ((state_q == ST_DEAD) && w_tmr_expire);
    assign w_tmr_val  = w_dead_start ? c_dead_ld : c_tmo_ld;
    assign w_tmr_en   = (state_q != ST_IDLE);
`else
    assign w_tmr_load = w_dead_start;
    assign w_tmr_val  = c_dead_ld;
    assign w_tmr_en   = (state_q == ST_DEAD);
`endif

    a2d_seq_tmr #(
        .WIDTH (c_tmr_w)
    ) u_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .en_i       (w_tmr_en),
        .expire_o   (w_tmr_expire)
    );

    // Sequencer FSM with all outputs registered; done wins over a
    // coincident timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            wrt_q       <= 1'b0;
            cmd_q       <= '0;
            res_q       <= '0;
            cnv_cmplt_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef A2D_SEQ_TMO_EN
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            wrt_q       <= 1'b0;
            cnv_cmplt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (nxt) begin
                        state_q <= ST_XFER1;
                        wrt_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cmd_q   <= chan_cmd(ptr_q);
                    end
                end
                ST_XFER1: begin
                    // First returned word is stale (pipelined ADC): discard.
                    if (done) begin
                        state_q <= ST_DEAD;
                    end
`ifdef A2D_SEQ_TMO_EN
                    else if (w_tmr_expire) begin
                        state_q   <= ST_IDLE;
                        ptr_q     <= ptr_q + 2'd1;
                        busy_q    <= 1'b0;
                        tmo_err_q <= 1'b1;
                    end
`endif
                end
                ST_DEAD: begin
                    if (w_tmr_expire) begin
                        state_q <= ST_XFER2;
                        wrt_q   <= 1'b1;
                    end
                end
                ST_XFER2: begin
                    if (done) begin
                        res_q[ptr_q] <= rd_data[11:0];
                        cnv_cmplt_q  <= 1'b1;
                        ptr_q        <= ptr_q + 2'd1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
`ifdef A2D_SEQ_TMO_EN
                    else if (w_tmr_expire) begin
                        state_q   <= ST_IDLE;
                        ptr_q     <= ptr_q + 2'd1;
                        busy_q    <= 1'b0;
                        tmo_err_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign lft_ld    = res_q[0];
    assign rght_ld   = res_q[1];
    assign steer_pot = res_q[2];
    assign batt      = res_q[3];
    assign cnv_cmplt = cnv_cmplt_q;
    assign busy      = busy_q;
`ifdef A2D_SEQ_TMO_EN
    assign tmo_err   = tmo_err_q;
`endif

endmodule : a2d_seq
`default_nettype wire

// File: tb/tb_a2d_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_a2d_seq
// Brief    : Self-checking bench for a2d_seq. A reactive SPI monarch model
//            answers each wrt after a random delay; expected channels,
//            result registers and pulse timing come from a slot-array model.
// Config   : A2D_SEQ_TMO_EN enables the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a2d_seq;

    localparam int DEAD = 4;
    localparam int TMO  = 2047;

    logic        clk = 1'b0;
    logic        rst;
    logic        nxt;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        cnv_cmplt;
    logic        busy;
`ifdef A2D_SEQ_TMO_EN
    logic        tmo_err;
`endif

    a2d_seq #(
        .DEAD_CYC (DEAD),
        .TMO_CYC  (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .rd_data   (rd_data),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
`ifdef A2D_SEQ_TMO_EN
        .tmo_err   (tmo_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: result slots, next slot, and the channel of each slot.
    int          chan_tab [4] = '{0, 4, 5, 6};
    logic [11:0] exp_res  [4];
    int          mptr;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_lft"},   32'(lft_ld),    32'(exp_res[0]));
        check({tag, "_rght"},  32'(rght_ld),   32'(exp_res[1]));
        check({tag, "_steer"}, 32'(steer_pot), 32'(exp_res[2]));
        check({tag, "_batt"},  32'(batt),      32'(exp_res[3]));
    endtask

    // One full conversion. Cycle 0 carries nxt (unless already armed by the
    // previous conversion); the monarch returns done t1/t2 cycles after each wrt.
    task automatic convert(input string tag, input logic [11:0] val,
                           input int t1, input int t2,
                           input bit noise, input bit pre_armed, input bit arm_next);
        int ch, w1, w2, nwrt, cnv_at, exp_w2, exp_cnv;
        ch      = chan_tab[mptr];
        exp_w2  = 1 + t1 + DEAD + 1;
        exp_cnv = exp_w2 + t2 + 1;
        w1 = -1; w2 = -1; nwrt = 0; cnv_at = -1;
        if (!pre_armed) begin
            @(negedge clk);
            nxt = 1'b1;
        end
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            nxt     = 1'b0;
            done    = 1'b0;
            rd_data = 16'($urandom);
            if (n == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (wrt) begin
                nwrt++;
                check({tag, "_cmd"}, 32'(cmd), 32'(ch << 11));
                if (w1 < 0) w1 = n;
                else if (w2 < 0) w2 = n;
            end
            if (cnv_cmplt) begin
                cnv_at = n;
                break;
            end
            if (noise && n == 2) nxt = 1'b1;
            if (noise && n == exp_w2 - 2) begin
                nxt  = 1'b1;
                done = 1'b1;
            end
            if (w1 > 0 && w2 < 0 && n == w1 + t1) done = 1'b1;
            if (w2 > 0 && n == w2 + t2) begin
                done    = 1'b1;
                rd_data = {4'($urandom), val};
            end
        end
        check({tag, "_wrt1_cyc"}, 32'(w1), 32'd1);
        check({tag, "_wrt2_cyc"}, 32'(w2), 32'(exp_w2));
        check({tag, "_nwrt"},     32'(nwrt), 32'd2);
        check({tag, "_latency"},  32'(cnv_at), 32'(exp_cnv));
        exp_res[mptr] = val;
        mptr = (mptr + 1) % 4;
        check_results(tag);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        if (arm_next) nxt = 1'b1;
    endtask

    // Watch a stretch of cycles for any spurious activity.
    task automatic quiet(input string tag, input int cycles);
        int nw, nc;
        nw = 0; nc = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            nxt  = 1'b0;
            done = 1'b0;
            if (wrt) nw++;
            if (cnv_cmplt) nc++;
        end
        check({tag, "_wrt"}, 32'(nw), 32'd0);
        check({tag, "_cnv"}, 32'(nc), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; nxt = 1'b0; done = 1'b0; rd_data = '0;
        mptr = 0;
        for (int i = 0; i < 4; i++) exp_res[i] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_wrt",  32'(wrt), 32'd0);
        check("rst_cmd",  32'(cmd), 32'd0);
        check("rst_cnv",  32'(cnv_cmplt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_results("rst");
`ifdef A2D_SEQ_TMO_EN
        check("rst_tmo", 32'(tmo_err), 32'd0);
`endif
        rst = 1'b0;

        // Four conversions with fixed values; the second has nxt and a stray
        // done injected mid-conversion.
        convert("c0_lft",   12'h350, $urandom_range(1, 5), $urandom_range(1, 5), 0, 0, 0);
        convert("c1_rght",  12'h340, $urandom_range(1, 5), $urandom_range(1, 5), 1, 0, 0);
        quiet("c1_after", 6);
        convert("c2_steer", 12'h800, $urandom_range(1, 5), $urandom_range(1, 5), 0, 0, 0);
        convert("c3_batt",  12'hC00, $urandom_range(1, 5), $urandom_range(1, 5), 0, 0, 0);

        // Pointer wrap: lft refreshes, others hold.
        convert("c4_wrap", 12'($urandom), $urandom_range(1, 5), $urandom_range(1, 5), 0, 0, 0);

        // nxt in the cnv_cmplt cycle is accepted: wrt on the next clock.
        convert("c5_b2b", 12'($urandom), 1, 1, 0, 0, 1);
        convert("c6_b2b", 12'($urandom), $urandom_range(1, 5), $urandom_range(1, 5), 0, 1, 0);

        // Reset during DEAD, then a late done from the abandoned transaction.
        @(negedge clk); nxt = 1'b1;
        @(negedge clk); nxt = 1'b0;
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_wrt",  32'(wrt), 32'd0);
        check("mid_rst_cmd",  32'(cmd), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) exp_res[i] = '0;
        mptr = 0;
        check_results("mid_rst");
        done = 1'b1; rd_data = 16'h0ABC;
        quiet("mid_rst_stray", 8);
        check("mid_rst_busy2", 32'(busy), 32'd0);
        check_results("mid_rst_hold");

        convert("r0_lft",  12'($urandom), $urandom_range(1, 5), $urandom_range(1, 5), 0, 0, 0);
        convert("r1_rght", 12'($urandom), $urandom_range(1, 5), $urandom_range(1, 5), 0, 0, 0);

`ifdef A2D_SEQ_TMO_EN
        // Withhold done on slot 2: abort exactly TMO clocks after wrt.
        begin
            int ncnv;
            ncnv = 0;
            @(negedge clk); nxt = 1'b1;
            for (int n = 1; n <= TMO + 10; n++) begin
                @(negedge clk);
                nxt = 1'b0; done = 1'b0;
                if (cnv_cmplt) ncnv++;
                if (n == 1) check("tmo_wrt", 32'(wrt), 32'd1);
                if (n == TMO) check("tmo_err_before", 32'(tmo_err), 32'd0);
                if (n == TMO + 1) begin
                    check("tmo_err_at", 32'(tmo_err), 32'd1);
                    check("tmo_busy", 32'(busy), 32'd0);
                    break;
                end
            end
            check("tmo_cnv", 32'(ncnv), 32'd0);
            mptr = (mptr + 1) % 4;
            check_results("tmo");
        end
        convert("tmo_next_batt", 12'($urandom), $urandom_range(1, 5), $urandom_range(1, 5), 0, 0, 0);
        check("tmo_sticky", 32'(tmo_err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_a2d_seq
`default_nettype wire
